// File: rtl/vid_in_axi4s_bridge_if.sv
// AXI4-Stream video channel used between the video-input bridge and its sink.
// The master drives data/markers; the slave returns tready.
interface vid_in_axi4s_bridge_if #(
  parameter int TDATA_WIDTH = 16
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/vid_in_axi4s_bridge.sv
// Parallel video (de/vsync/data) to AXI4-Stream video master: frames pixels with
// tuser/tlast through a one-pixel stage and buffers them in a show-ahead FIFO.
module vid_in_axi4s_bridge #(
  parameter int DATA_WIDTH     = 12,
  parameter int TDATA_WIDTH    = 16,
  parameter int FIFO_ADDR_BITS = 10
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  video_de,
  input  logic                  video_vsync,
  input  logic [DATA_WIDTH-1:0] video_data,
  vid_in_axi4s_bridge_if.master m_axis_video,
  output logic                  locked,
  output logic                  overflow,
  output logic                  empty,
  output logic [12:0]           active_width,
  output logic [12:0]           active_height
);

  localparam int DEPTH   = 1 << FIFO_ADDR_BITS;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam logic [FIFO_ADDR_BITS:0] FULL_CNT = (FIFO_ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  vsync_q;
  logic                  vsync_edge;
  logic                  sof_pending_q, sof_pending_d;
  logic                  stg_valid_q, stg_valid_d;
  logic                  stg_sof_q, stg_sof_d;
  logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;

  logic [ENTRY_W-1:0]        mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_BITS:0]   count_q;
  logic [ENTRY_W-1:0]        head;
  logic                      fifo_empty, fifo_full;
  logic                      wr_req, wr_eol, wr_ok, wr_drop, rd_fire;

  logic        overflow_q;
  logic [12:0] pix_cnt_q, pix_cnt_d;
  logic [12:0] line_cnt_q, line_cnt_d;
  logic [12:0] width_q, width_d;
  logic [12:0] height_q, height_d;

  function automatic logic [12:0] sat_inc(input logic [12:0] v);
    return (v == 13'h1FFF) ? v : v + 13'd1;
  endfunction

  assign vsync_edge = video_vsync & ~vsync_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign rd_fire    = ~fifo_empty & m_axis_video.tready;

  // A full stage always leaves this cycle: either pushed out by a new pixel
  // (eol=0) or flushed as the line's last pixel once de falls (eol=1).
  assign wr_req  = (state_q == ST_ACTIVE) & stg_valid_q;
  assign wr_eol  = ~video_de;
  assign wr_ok   = wr_req & (~fifo_full | rd_fire);
  assign wr_drop = wr_req & ~wr_ok;

  always_comb begin
    state_d       = state_q;
    sof_pending_d = sof_pending_q;
    stg_valid_d   = stg_valid_q;
    stg_sof_d     = stg_sof_q;
    stg_data_d    = stg_data_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    width_d       = width_q;
    height_d      = height_q;

    case (state_q)
      ST_IDLE, ST_DROP: begin
        stg_valid_d = 1'b0;
        stg_sof_d   = 1'b0;
        if (vsync_edge) begin
          // Resynchronise: partial counts from before the gap are meaningless.
          state_d       = ST_ACTIVE;
          sof_pending_d = 1'b1;
          pix_cnt_d     = '0;
          line_cnt_d    = '0;
        end
      end

      ST_ACTIVE: begin
        if (video_de) begin
          stg_valid_d   = 1'b1;
          stg_data_d    = video_data;
          stg_sof_d     = sof_pending_q | vsync_edge;
          sof_pending_d = 1'b0;
          pix_cnt_d     = sat_inc(pix_cnt_q);
        end else begin
          if (vsync_edge) sof_pending_d = 1'b1;
          if (stg_valid_q) stg_valid_d = 1'b0;
        end

        if (wr_ok && wr_eol) begin
          width_d    = pix_cnt_q;
          pix_cnt_d  = '0;
          line_cnt_d = sat_inc(line_cnt_q);
        end

        if (vsync_edge) begin
          height_d   = line_cnt_d;
          line_cnt_d = '0;
        end

        if (wr_drop) begin
          state_d     = ST_DROP;
          stg_valid_d = 1'b0;
          stg_sof_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      vsync_q       <= 1'b0;
      sof_pending_q <= 1'b0;
      stg_valid_q   <= 1'b0;
      stg_sof_q     <= 1'b0;
      stg_data_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      width_q       <= '0;
      height_q      <= '0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= video_vsync;
      sof_pending_q <= sof_pending_d;
      stg_valid_q   <= stg_valid_d;
      stg_sof_q     <= stg_sof_d;
      stg_data_q    <= stg_data_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      width_q       <= width_d;
      height_q      <= height_d;

      if (wr_drop) overflow_q <= 1'b1;
      if (wr_ok)   wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q   <= rd_ptr_q + 1'b1;

      case ({wr_ok, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; outputs are gated by the occupancy count instead.
  always_ff @(posedge aclk) begin
    if (wr_ok) mem[wr_ptr_q] <= {stg_sof_q, wr_eol, stg_data_q};
  end

  assign head = mem[rd_ptr_q];

  assign m_axis_video.tvalid = ~fifo_empty;
  assign m_axis_video.tdata  = fifo_empty ? '0 : TDATA_WIDTH'(head[DATA_WIDTH-1:0]);
  assign m_axis_video.tuser  = ~fifo_empty & head[ENTRY_W-1];
  assign m_axis_video.tlast  = ~fifo_empty & head[ENTRY_W-2];

  assign locked        = (state_q == ST_ACTIVE);
  assign overflow      = overflow_q;
  assign empty         = fifo_empty;
  assign active_width  = width_q;
  assign active_height = height_q;

endmodule

// File: tb/tb_vid_in_axi4s_bridge.sv
// Bench for vid_in_axi4s_bridge: a deep instance (A) for framing, backpressure and
// reset, a 16-entry instance (B) for overflow and full-FIFO behaviour.
module tb_vid_in_axi4s_bridge;
  localparam int DW = 12;
  localparam int TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1;
  logic          rst_b = 1'b1;
  logic          de    = 1'b0;
  logic          vs    = 1'b0;
  logic [DW-1:0] data  = '0;

  vid_in_axi4s_bridge_if #(.TDATA_WIDTH(TW)) axis_a ();
  vid_in_axi4s_bridge_if #(.TDATA_WIDTH(TW)) axis_b ();

  logic        locked_a, ovf_a, empty_a, locked_b, ovf_b, empty_b;
  logic [12:0] aw_a, ah_a, aw_b, ah_b;

  vid_in_axi4s_bridge #(.DATA_WIDTH(DW), .TDATA_WIDTH(TW), .FIFO_ADDR_BITS(10)) u_dut_a (
    .aclk(clk), .rst(rst_a), .video_de(de), .video_vsync(vs), .video_data(data),
    .m_axis_video(axis_a), .locked(locked_a), .overflow(ovf_a), .empty(empty_a),
    .active_width(aw_a), .active_height(ah_a)
  );

  vid_in_axi4s_bridge #(.DATA_WIDTH(DW), .TDATA_WIDTH(TW), .FIFO_ADDR_BITS(4)) u_dut_b (
    .aclk(clk), .rst(rst_b), .video_de(de), .video_vsync(vs), .video_data(data),
    .m_axis_video(axis_b), .locked(locked_b), .overflow(ovf_b), .empty(empty_b),
    .active_width(aw_b), .active_height(ah_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_beats_a = 0;
  int n_beats_b = 0;
  bit bp_mode = 1'b0;

  logic [17:0] exp_a[$];
  logic [17:0] exp_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) axis_a.tready = ~axis_a.tready;
  endtask

  task automatic vsync_pulse();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drive_line(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      de   = 1'b1;
      data = DW'(base + i);
      tick();
    end
    de   = 1'b0;
    data = '0;
    repeat (4) tick();
  endtask

  task automatic push_line(input bit to_b, input int n, input int base, input bit sof, input bit eol_en);
    logic [17:0] e;
    for (int i = 0; i < n; i++) begin
      e = {sof && (i == 0), eol_en && (i == n - 1), 16'(DW'(base + i))};
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
  endtask

  task automatic frame_lines_a(input int w, input int h, input int base);
    for (int l = 0; l < h; l++) begin
      push_line(1'b0, w, base + l * w, l == 0, 1'b1);
      drive_line(w, base + l * w);
    end
  endtask

  task automatic wait_drain(input bit to_b);
    int k = 0;
    while (((to_b ? exp_b.size() : exp_a.size()) != 0) && k < 3000) begin
      tick();
      k++;
    end
    if (to_b) check("b_drain_left", 32'(exp_b.size()), 32'd0);
    else      check("a_drain_left", 32'(exp_a.size()), 32'd0);
  endtask

  task automatic check_a_reset();
    check("a_rst_tvalid", 32'(axis_a.tvalid), 32'd0);
    check("a_rst_tuser",  32'(axis_a.tuser),  32'd0);
    check("a_rst_tlast",  32'(axis_a.tlast),  32'd0);
    check("a_rst_tdata",  32'(axis_a.tdata),  32'd0);
    check("a_rst_locked", 32'(locked_a),      32'd0);
    check("a_rst_ovf",    32'(ovf_a),         32'd0);
    check("a_rst_empty",  32'(empty_a),       32'd1);
    check("a_rst_width",  32'(aw_a),          32'd0);
    check("a_rst_height", 32'(ah_a),          32'd0);
  endtask

  // Monitors: pop the scoreboard on each handshake, and check hold-steady while stalled.
  initial begin : mon_a
    bit          stall = 1'b0;
    logic [17:0] hold  = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        stall = 1'b0;
      end else begin
        if (stall)
          check("a_stall_stable", 32'({axis_a.tvalid, axis_a.tuser, axis_a.tlast, axis_a.tdata}),
                32'({1'b1, hold}));
        if (axis_a.tvalid && axis_a.tready) begin
          check("a_beat_expected", 32'(exp_a.size() != 0), 32'd1);
          if (exp_a.size() != 0)
            check("a_beat", 32'({axis_a.tuser, axis_a.tlast, axis_a.tdata}), 32'(exp_a.pop_front()));
          n_beats_a++;
        end
        stall = axis_a.tvalid && !axis_a.tready;
        hold  = {axis_a.tuser, axis_a.tlast, axis_a.tdata};
      end
    end
  end

  initial begin : mon_b
    forever begin
      @(negedge clk);
      if (!rst_b && axis_b.tvalid && axis_b.tready) begin
        check("b_beat_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0)
          check("b_beat", 32'({axis_b.tuser, axis_b.tlast, axis_b.tdata}), 32'(exp_b.pop_front()));
        n_beats_b++;
      end
    end
  end

  initial begin : stim
    int start;
    axis_a.tready = 1'b1;
    axis_b.tready = 1'b0;
    repeat (4) tick();
    rst_a = 1'b0;
    tick();
    check_a_reset();

    // Pixels before any vsync are ignored.
    drive_line(4, 'h100);
    check("a_prevs_tvalid", 32'(axis_a.tvalid), 32'd0);
    check("a_prevs_locked", 32'(locked_a), 32'd0);

    // 4x3 frame with tready held high.
    vsync_pulse();
    check("a_locked", 32'(locked_a), 32'd1);
    start = n_beats_a;
    frame_lines_a(4, 3, 'h200);
    vsync_pulse();
    wait_drain(1'b0);
    check("a_beats_4x3", 32'(n_beats_a - start), 32'd12);
    check("a_width_4",   32'(aw_a), 32'd4);
    check("a_height_3",  32'(ah_a), 32'd3);

    // Two 8x4 frames with tready toggling every cycle.
    bp_mode = 1'b1;
    frame_lines_a(8, 4, 'h300);
    vsync_pulse();
    frame_lines_a(8, 4, 'h340);
    vsync_pulse();
    bp_mode = 1'b0;
    axis_a.tready = 1'b1;
    wait_drain(1'b0);
    check("a_width_8",  32'(aw_a), 32'd8);
    check("a_height_4", 32'(ah_a), 32'd4);

    // Reset pulsed in the middle of a line.
    push_line(1'b0, 10, 'h380, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      de = 1'b1; data = DW'('h380 + i); tick();
    end
    rst_a = 1'b1;
    tick();
    check_a_reset();
    rst_a = 1'b0;
    exp_a.delete();
    for (int i = 5; i < 10; i++) begin
      de = 1'b1; data = DW'('h380 + i); tick();
    end
    de = 1'b0;
    repeat (20) tick();
    check("a_postrst_tvalid", 32'(axis_a.tvalid), 32'd0);
    check("a_postrst_locked", 32'(locked_a), 32'd0);

    // Overflow on the 16-entry instance with tready low.
    rst_a = 1'b1;
    rst_b = 1'b0;
    tick();
    check("b_rst_ovf", 32'(ovf_b), 32'd0);
    vsync_pulse();
    push_line(1'b1, 16, 'h400, 1'b1, 1'b0);
    drive_line(20, 'h400);
    check("b_ovf_set",    32'(ovf_b), 32'd1);
    check("b_ovf_locked", 32'(locked_b), 32'd0);
    check("b_ovf_tvalid", 32'(axis_b.tvalid), 32'd1);
    drive_line(6, 'h500);
    start = n_beats_b;
    axis_b.tready = 1'b1;
    wait_drain(1'b1);
    repeat (5) tick();
    check("b_held_16", 32'(n_beats_b - start), 32'd16);
    check("b_empty",   32'(empty_b), 32'd1);
    vsync_pulse();
    check("b_relock", 32'(locked_b), 32'd1);
    push_line(1'b1, 3, 'h600, 1'b1, 1'b1);
    drive_line(3, 'h600);
    wait_drain(1'b1);
    check("b_ovf_sticky", 32'(ovf_b), 32'd1);

    // Full FIFO with a read in the same cycle as the eol write.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    axis_b.tready = 1'b0;
    vsync_pulse();
    push_line(1'b1, 17, 'h700, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      de = 1'b1; data = DW'('h700 + i); tick();
    end
    de = 1'b0;
    axis_b.tready = 1'b1;
    tick();
    check("b_full_rw_ovf", 32'(ovf_b), 32'd0);
    wait_drain(1'b1);
    check("b_full_rw_ovf_end", 32'(ovf_b), 32'd0);
    check("b_full_rw_locked",  32'(locked_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
